// File: rtl/carbonio_irq_prio_router.sv
`default_nettype none
// ============================================================================
// carbonio_irq_prio_router
//   Priority interrupt router with edge/level sources, threshold, nesting.
//   Revision: 1.0
// ============================================================================
module carbonio_irq_prio_router #(
   parameter  int N_SOURCES = 8,
   parameter  int PRIO_W    = 3,
   localparam int VEC_W     = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_SOURCES-1:0]        src_in,
   input  logic [N_SOURCES-1:0]        mode,
   input  logic [N_SOURCES-1:0]        enable,
   input  logic [N_SOURCES-1:0]        clear,
   input  logic [N_SOURCES*PRIO_W-1:0] prio_cfg,
   input  logic [PRIO_W-1:0]           threshold,
   input  logic                        irq_ack,
   input  logic [VEC_W-1:0]            irq_ack_vector,
   input  logic                        irq_eoi,
   input  logic [VEC_W-1:0]            irq_eoi_vector,
   output logic [N_SOURCES-1:0]        pending,
   output logic [N_SOURCES-1:0]        in_service,
   output logic                        irq_valid,
   output logic [VEC_W-1:0]            irq_vector,
   output logic [PRIO_W-1:0]           irq_prio,
   output logic                        ack_err
);

   logic [N_SOURCES-1:0] r_src_prev;
   logic [N_SOURCES-1:0] r_pending;
   logic [N_SOURCES-1:0] r_in_service;
   logic                 r_irq_valid;
   logic [VEC_W-1:0]     r_irq_vector;
   logic [PRIO_W-1:0]    r_irq_prio;
   logic                 r_ack_err;

   logic                 w_ack_hit;
   logic [N_SOURCES-1:0] w_rise;
   logic [N_SOURCES-1:0] w_ack_clr;
   logic [N_SOURCES-1:0] w_eoi_clr;
   logic [N_SOURCES-1:0] w_pending_d;
   logic [N_SOURCES-1:0] w_in_service_d;
   logic [PRIO_W-1:0]    w_floor;
   logic                 w_win_found;
   logic [VEC_W-1:0]     w_win_idx;
   logic [PRIO_W-1:0]    w_win_prio;

   assign w_ack_hit = irq_ack && r_irq_valid && (irq_ack_vector == r_irq_vector);
   assign w_rise    = src_in & ~r_src_prev;

   // A new edge wins over clear and ack in the same cycle; ack wins over EOI.
   always_comb begin
      w_ack_clr      = '0;
      w_eoi_clr      = '0;
      w_pending_d    = '0;
      w_in_service_d = '0;
      for (int i = 0; i < N_SOURCES; i++) begin
         w_ack_clr[i] = w_ack_hit && (r_irq_vector == VEC_W'(i));
         w_eoi_clr[i] = irq_eoi && (irq_eoi_vector == VEC_W'(i));
         if (mode[i])
            w_pending_d[i] = src_in[i];
         else
            w_pending_d[i] = ((r_pending[i] | w_rise[i]) & ~clear[i] & ~w_ack_clr[i]) | w_rise[i];
         w_in_service_d[i] = (r_in_service[i] & ~w_eoi_clr[i]) | w_ack_clr[i];
      end
   end

   // Selection works on next-state values so an acked vector is never re-shown.
   always_comb begin
      w_floor     = threshold;
      w_win_found = 1'b0;
      w_win_idx   = '0;
      w_win_prio  = '0;
      for (int i = 0; i < N_SOURCES; i++) begin
         if (w_in_service_d[i] && (prio_cfg[i*PRIO_W +: PRIO_W] > w_floor))
            w_floor = prio_cfg[i*PRIO_W +: PRIO_W];
      end
      for (int i = 0; i < N_SOURCES; i++) begin
         if (w_pending_d[i] && enable[i] && !w_in_service_d[i] &&
             (prio_cfg[i*PRIO_W +: PRIO_W] > w_floor) &&
             (!w_win_found || (prio_cfg[i*PRIO_W +: PRIO_W] > w_win_prio))) begin
            w_win_found = 1'b1;
            w_win_idx   = VEC_W'(i);
            w_win_prio  = prio_cfg[i*PRIO_W +: PRIO_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src_prev   <= '0;
         r_pending    <= '0;
         r_in_service <= '0;
         r_irq_valid  <= 1'b0;
         r_irq_vector <= '0;
         r_irq_prio   <= '0;
         r_ack_err    <= 1'b0;
      end else begin
         r_src_prev   <= src_in;
         r_pending    <= w_pending_d;
         r_in_service <= w_in_service_d;
         r_irq_valid  <= w_win_found;
         r_irq_vector <= w_win_idx;
         r_irq_prio   <= w_win_prio;
         r_ack_err    <= irq_ack && !w_ack_hit;
      end
   end

   assign pending    = r_pending;
   assign in_service = r_in_service;
   assign irq_valid  = r_irq_valid;
   assign irq_vector = r_irq_vector;
   assign irq_prio   = r_irq_prio;
   assign ack_err    = r_ack_err;

endmodule
`default_nettype wire

// File: doc/carbonio_irq_prio_router.md
Name: carbonio_irq_prio_router

Overview:
- Parametrised interrupt router for CarbonIO peripherals.
- Per-source edge/level mode, programmable per-source priority, global threshold, and in-service tracking with acknowledge/end-of-interrupt (EOI).
- Presents one registered highest-priority request to the CPU-side interrupt controller.
- Nested preemption: only strictly higher priority than the highest in-service source is presented.

Parameters:
N_SOURCES, 8, number of interrupt sources (1..64).
PRIO_W, 3, priority field width; larger value = higher priority.
VEC_W, derived = max(1, clog2(N_SOURCES)), vector width; not user-overridable.

Ports:
clk  in  1  clock.
rst_n  in  1  reset, asynchronous, active-low.
src_in  in  N_SOURCES  raw source lines, synchronous to clk.
mode  in  N_SOURCES  per source: 1 = level, 0 = rising edge.
enable  in  N_SOURCES  per-source enable for presentation; pending still latches when 0.
clear  in  N_SOURCES  clears edge-mode pending bits; ignored for level sources.
prio_cfg  in  N_SOURCES*PRIO_W  source i priority at bits [i*PRIO_W +: PRIO_W].
threshold  in  PRIO_W  only priority > threshold is presented.
irq_ack  in  1  acknowledge strobe.
irq_ack_vector  in  VEC_W  vector being acknowledged.
irq_eoi  in  1  end-of-interrupt strobe.
irq_eoi_vector  in  VEC_W  vector being retired.
pending  out  N_SOURCES  registered pending state.
in_service  out  N_SOURCES  registered in-service state.
irq_valid  out  1  registered request valid.
irq_vector  out  VEC_W  registered selected source index.
irq_prio  out  PRIO_W  registered priority of irq_vector.
ack_err  out  1  one-cycle pulse on a rejected ack.

Behaviour:
- Reset: pending, in_service, src_prev, irq_valid, irq_vector, irq_prio and ack_err all 0. A source high at the first post-reset edge registers as a rising edge.
- Edge detect: rise[i] = src_in[i] & ~src_prev[i]; src_prev <= src_in every cycle.
- Edge-mode next pending: (pending | rise) & ~clear & ~ack_clr, then OR rise. A new edge wins over both clear and ack in the same cycle.
- Level-mode next pending: src_in[i]. clear and ack have no effect on it.
- Ack acceptance: accepted iff irq_ack=1 & irq_valid=1 & irq_ack_vector == irq_vector, using registered outputs.
  - Accepted: ack_clr[vector] clears pending (edge mode only) and sets in_service[vector].
  - Rejected (any other irq_ack=1): no state change; ack_err=1 for one cycle.
- EOI: irq_eoi with irq_eoi_vector < N_SOURCES clears that in_service bit; out-of-range vectors are ignored. Ack and EOI on the same vector in the same cycle: ack wins, bit stays set.
- Selection, computed from next-state values so outputs never show a stale, already-acked vector:
  - cand = pending_d & enable & ~in_service_d & (prio > floor).
  - floor = max(threshold, highest prio among in_service_d bits); if none are in service, floor = threshold.
  - Winner = highest prio; ties go to the lowest index.
  - irq_valid = |cand. irq_vector/irq_prio = winner; both 0 when no candidate.
- Latency: a rising src_in sampled at edge k gives pending=1 and irq_valid=1 after edge k (one cycle).
- Config (mode, enable, prio_cfg, threshold) is sampled every cycle; changes take effect at the next edge.
- Edge→level switch: pending follows src_in. Level→edge switch: pending holds until cleared or acked.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

Test Plan:
- Edge source 2, prio 5, threshold 0: pulse src_in[2] one cycle → pending[2]=1, irq_valid=1, vector=2, prio=5 after that edge. Ack vector 2 → pending[2]=0, in_service[2]=1, irq_valid=0 next edge.
- Priority and tie-break: sources 1 and 6 at prio 4, source 3 at prio 2, all pending → vector=1. After ack of 1, in_service prio 4 blocks 6 and 3 → irq_valid=0. EOI 1 → vector=6.
- Nesting: source 0 (prio 2) in service, source 5 (prio 6) fires → vector=5 presented and acked. EOI 5 then EOI 0 → in_service returns to 0.
- Level source 4, prio 3: held high through ack → pending stays 1, re-presented after EOI. Drop src_in → pending=0 next edge.
- Collisions: edge on source 7 in the same cycle as clear[7] and an ack of 7 → pending[7] stays 1. Ack vector 3 while irq_vector=7 → ack_err pulse, no state change.
- Threshold 5 with source at prio 5 → irq_valid=0; set threshold 4 → irq_valid=1 next edge. Assert rst_n=0 mid-request → all outputs 0 immediately.
